seq_011_tx: RTL and testbench

SEQ_011_TX -- requirements
Module: seq_011_tx

---
 rtl/seq_011_tx.sv | 132 +++++++++++++
 tb/tb_seq_011_tx.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/seq_011_tx.sv
// rtl/seq_011_tx.sv - Moore serial framer: "011" sync header then DATA_W payload bits MSB first
// Optional feature macro: TX_PARITY_EN (adds an even-parity bit after the payload).
module seq_011_tx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              dout,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SYNC0  = 3'd1;
  localparam logic [2:0] ST_SYNC1  = 3'd2;
  localparam logic [2:0] ST_SYNC2  = 3'd3;
  localparam logic [2:0] ST_DATA   = 3'd4;
`ifdef TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd5;
`endif

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
`ifdef TX_PARITY_EN
  logic              par_q, par_d;
`endif

  // State register: every flop clears asynchronously so a mid-frame reset aborts cleanly
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
`ifdef TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
`ifdef TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state logic: accept in IDLE, walk the header, then shift out the payload
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
`ifdef TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // in_ready is 1 only here, so acceptance reduces to in_valid
        if (in_valid) begin
          state_d = ST_SYNC0;
          shift_d = in_data;
`ifdef TX_PARITY_EN
          par_d   = ^in_data;
`endif
        end
      end
      ST_SYNC0: state_d = ST_SYNC1;
      ST_SYNC1: state_d = ST_SYNC2;
      ST_SYNC2: begin
        state_d = ST_DATA;
        cnt_d   = CNT_W'(DATA_W - 1);
      end
      ST_DATA: begin
        shift_d = shift_q << 1;
        if (cnt_q == '0) begin
`ifdef TX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_IDLE;
`endif
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef TX_PARITY_EN
      ST_PARITY: state_d = ST_IDLE;
`endif
      // Unused encodings recover to IDLE on the next edge
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode: purely from registered state, never from inputs
  always_comb begin
    dout     = 1'b1;
    in_ready = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      ST_SYNC0: dout = 1'b0;
      ST_SYNC1: dout = 1'b1;
      ST_SYNC2: dout = 1'b1;
      ST_DATA: begin
        dout = shift_q[DATA_W-1];
`ifndef TX_PARITY_EN
        done = (cnt_q == '0);
`endif
      end
`ifdef TX_PARITY_EN
      ST_PARITY: begin
        dout = par_q;
        done = 1'b1;
      end
`endif
      default: begin
        // Unreachable encodings look exactly like IDLE
        in_ready = 1'b1;
        busy     = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_011_tx.sv
// tb/tb_seq_011_tx.sv - self-checking bench for seq_011_tx against a frame-list reference model
module tb_seq_011_tx;

  localparam int DATA_W = 8;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              dout;
  logic              busy;
  logic              done;

  int total = 0;
  int bad   = 0;

  seq_011_tx #(.DATA_W(DATA_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .dout     (dout),
    .busy     (busy),
    .done     (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the line bits of one frame, header "011" then payload MSB first (+ even parity)
  function automatic void frame_bits(input logic [DATA_W-1:0] w, output bit q[$]);
    q = {};
    q.push_back(1'b0);
    q.push_back(1'b1);
    q.push_back(1'b1);
    for (int i = DATA_W - 1; i >= 0; i--) q.push_back(w[i]);
`ifdef TX_PARITY_EN
    q.push_back(^w);
`endif
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, ".dout"},  32'(dout),     32'd1);
    chk({tag, ".ready"}, 32'(in_ready), 32'd1);
    chk({tag, ".busy"},  32'(busy),     32'd0);
    chk({tag, ".done"},  32'(done),     32'd0);
  endtask

  // Called on the negedge following the accepting edge; checks cycles [first, last)
  // of the frame. A different word is offered during cycle glitch_at (header SYNC1).
  task automatic check_frame(input string tag, input logic [DATA_W-1:0] w,
                             input int first, input int last, input int glitch_at);
    bit q[$];
    frame_bits(w, q);
    for (int k = first; k < last; k++) begin
      chk($sformatf("%s.dout[%0d]", tag, k),  32'(dout),     32'(q[k]));
      chk($sformatf("%s.busy[%0d]", tag, k),  32'(busy),     32'd1);
      chk($sformatf("%s.ready[%0d]", tag, k), 32'(in_ready), 32'd0);
      chk($sformatf("%s.done[%0d]", tag, k),  32'(done),     32'(k == q.size() - 1));
      if (k == glitch_at) begin
        in_valid = 1'b1;
        in_data  = ~w;
      end else if (glitch_at >= 0) begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  function automatic int flen();
    bit q[$];
    frame_bits('0, q);
    return q.size();
  endfunction

  // Offer w at the current negedge (block is IDLE), accept it, check whole frame and trailing idle
  task automatic send(input string tag, input logic [DATA_W-1:0] w, input int glitch_at);
    chk({tag, ".ready_pre"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = DATA_W'($urandom);
    check_frame(tag, w, 0, flen(), glitch_at);
    in_valid = 1'b0;
    chk_idle({tag, ".after"});
  endtask

  initial begin
    logic [DATA_W-1:0] w;
    int gaps;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;

    // Reset state
    #3;
    chk_idle("reset");

    // Release, and accept on the very first edge after release
    @(negedge clk);
    reset = 1'b1;
    send("a5", 8'hA5, -1);

    // Word held valid across a frame: exactly one idle gap, accepted there
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h00;
    @(negedge clk);
    in_data  = 8'hFF;
    check_frame("b2b0", 8'h00, 0, flen(), -1);
    chk_idle("b2b_gap");
    @(negedge clk);
    in_valid = 1'b0;
    check_frame("b2b1", 8'hFF, 0, flen(), -1);
    chk_idle("b2b_after");

    // Offer a different word during SYNC1: ignored, frame unchanged
    @(negedge clk);
    send("glitch", 8'h5A, 1);

    // Reset mid-frame during DATA bit 4 of 8'h3C
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h3C;
    @(negedge clk);
    in_valid = 1'b0;
    check_frame("rst", 8'h3C, 0, 3 + 4, -1);
    chk("rst.bit4", 32'(dout), 32'(1'b1));
    #1 reset = 1'b0;
    #1 chk_idle("rst.async");
    #1 reset = 1'b1;
    w = 8'hC3;
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
    in_valid = 1'b0;
    check_frame("rst.new", w, 0, flen(), -1);
    chk_idle("rst.new_after");

    // Random words with random idle gaps
    for (int n = 0; n < 16; n++) begin
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        @(negedge clk);
        chk_idle($sformatf("rnd%0d.gap", n));
      end
      @(negedge clk);
      send($sformatf("rnd%0d", n), DATA_W'($urandom), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
